tx_ffe_sweep_ctrl: RTL and testbench

// Sequencer that configures the TX FFE by sweeping its tx_setting code over a

---
 rtl/tx_ffe_sweep_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tx_ffe_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ffe_sweep_ctrl.sv
// TX FFE setting sweep sequencer: settles, measures RX errors per code over a
// dwell window, then applies the code with the fewest errors.
module tx_ffe_sweep_ctrl #(
   parameter int TX_SETTING_WIDTH = 4,
   parameter int DWELL_WIDTH      = 16,
   parameter int SETTLE_CYCLES    = 64,
   parameter int DEFAULT_SETTING  = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [TX_SETTING_WIDTH-1:0] setting_min,
   input  logic [TX_SETTING_WIDTH-1:0] setting_max,
   input  logic [DWELL_WIDTH-1:0]      dwell_cycles,
   input  logic                        err_in,
   output logic [TX_SETTING_WIDTH-1:0] tx_setting,
   output logic                        busy,
   output logic                        done,
   output logic                        range_err,
   output logic [TX_SETTING_WIDTH-1:0] best_setting,
   output logic [DWELL_WIDTH-1:0]      best_err_count
);

   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int CNT_W    = (DWELL_WIDTH > SETTLE_W) ? DWELL_WIDTH : SETTLE_W;

   localparam logic [CNT_W-1:0]            SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]            CNT_ONE     = CNT_W'(1);
   localparam logic [TX_SETTING_WIDTH-1:0] SET_ONE     = TX_SETTING_WIDTH'(1);
   localparam logic [TX_SETTING_WIDTH-1:0] SET_DEF     = TX_SETTING_WIDTH'(DEFAULT_SETTING);
   localparam logic [DWELL_WIDTH-1:0]      ERR_ONE     = DWELL_WIDTH'(1);
   localparam logic [DWELL_WIDTH-1:0]      ERR_ALL     = '1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_COMPARE = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   state_t                        state_q, state_d;
   logic [TX_SETTING_WIDTH-1:0]   tx_q, tx_d;
   logic [TX_SETTING_WIDTH-1:0]   min_q, min_d;
   logic [TX_SETTING_WIDTH-1:0]   max_q, max_d;
   logic [TX_SETTING_WIDTH-1:0]   restore_q, restore_d;
   logic [DWELL_WIDTH-1:0]        dwell_last_q, dwell_last_d;
   logic [CNT_W-1:0]              cyc_q, cyc_d;
   logic [DWELL_WIDTH-1:0]        err_q, err_d;
   logic [TX_SETTING_WIDTH-1:0]   run_code_q, run_code_d;
   logic [DWELL_WIDTH-1:0]        run_cnt_q, run_cnt_d;
   logic [TX_SETTING_WIDTH-1:0]   best_set_q, best_set_d;
   logic [DWELL_WIDTH-1:0]        best_cnt_q, best_cnt_d;
   logic                          done_q, done_d;
   logic                          range_err_q, range_err_d;
   logic                          range_bad;

   assign range_bad = setting_min > setting_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tx_q         <= SET_DEF;
         min_q        <= '0;
         max_q        <= '0;
         restore_q    <= SET_DEF;
         dwell_last_q <= '0;
         cyc_q        <= '0;
         err_q        <= '0;
         run_code_q   <= SET_DEF;
         run_cnt_q    <= ERR_ALL;
         best_set_q   <= SET_DEF;
         best_cnt_q   <= ERR_ALL;
         done_q       <= 1'b0;
         range_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_q         <= tx_d;
         min_q        <= min_d;
         max_q        <= max_d;
         restore_q    <= restore_d;
         dwell_last_q <= dwell_last_d;
         cyc_q        <= cyc_d;
         err_q        <= err_d;
         run_code_q   <= run_code_d;
         run_cnt_q    <= run_cnt_d;
         best_set_q   <= best_set_d;
         best_cnt_q   <= best_cnt_d;
         done_q       <= done_d;
         range_err_q  <= range_err_d;
      end
   end

   // Abort takes priority over every non-idle transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !range_bad) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (abort)                     state_d = ST_IDLE;
            else if (cyc_q == SETTLE_LAST) state_d = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (abort)                               state_d = ST_IDLE;
            else if (cyc_q == CNT_W'(dwell_last_q))  state_d = ST_COMPARE;
         end
         ST_COMPARE: begin
            if (abort)               state_d = ST_IDLE;
            else if (tx_q == max_q)  state_d = ST_FINISH;
            else                     state_d = ST_SETTLE;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_d         = tx_q;
      min_d        = min_q;
      max_d        = max_q;
      restore_d    = restore_q;
      dwell_last_d = dwell_last_q;
      cyc_d        = cyc_q;
      err_d        = err_q;
      run_code_d   = run_code_q;
      run_cnt_d    = run_cnt_q;
      best_set_d   = best_set_q;
      best_cnt_d   = best_cnt_q;
      done_d       = 1'b0;
      range_err_d  = 1'b0;
      if (state_q == ST_IDLE) begin
         if (start) begin
            min_d        = setting_min;
            max_d        = setting_max;
            dwell_last_d = (dwell_cycles == '0) ? '0 : dwell_cycles - ERR_ONE;
            restore_d    = tx_q;
            if (range_bad) begin
               range_err_d = 1'b1;
            end else begin
               tx_d       = setting_min;
               run_code_d = setting_min;
               run_cnt_d  = ERR_ALL;
               cyc_d      = '0;
               err_d      = '0;
            end
         end
      end else if (abort) begin
         tx_d = restore_q;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               cyc_d = (cyc_q == SETTLE_LAST) ? '0 : cyc_q + CNT_ONE;
            end
            ST_MEASURE: begin
               cyc_d = cyc_q + CNT_ONE;
               if (err_in && (err_q != ERR_ALL)) err_d = err_q + ERR_ONE;
            end
            ST_COMPARE: begin
               // Strict less-than keeps the lower code on ties.
               if (err_q < run_cnt_q) begin
                  run_code_d = tx_q;
                  run_cnt_d  = err_q;
               end
               if (tx_q != max_q) begin
                  tx_d  = tx_q + SET_ONE;
                  cyc_d = '0;
                  err_d = '0;
               end
            end
            ST_FINISH: begin
               tx_d       = run_code_q;
               best_set_d = run_code_q;
               best_cnt_d = run_cnt_q;
               done_d     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign tx_setting     = tx_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;
   assign range_err      = range_err_q;
   assign best_setting   = best_set_q;
   assign best_err_count = best_cnt_q;

endmodule

// File: tb/tb_tx_ffe_sweep_ctrl.sv
// Directed bench for tx_ffe_sweep_ctrl; sweep results are queued when a sweep
// is launched and checked against the DUT when done pulses.
module tb_tx_ffe_sweep_ctrl;

   localparam int SETTLE = 64;

   logic        clk = 1'b0;
   logic        rst, start, abort, err_in;
   logic [3:0]  setting_min, setting_max;
   logic [15:0] dwell_cycles;
   logic [3:0]  tx_setting, best_setting;
   logic        busy, done, range_err;
   logic [15:0] best_err_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  best;
      logic [15:0] cnt;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   rate[16];

   tx_ffe_sweep_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .setting_min    (setting_min),
      .setting_max    (setting_max),
      .dwell_cycles   (dwell_cycles),
      .err_in         (err_in),
      .tx_setting     (tx_setting),
      .busy           (busy),
      .done           (done),
      .range_err      (range_err),
      .best_setting   (best_setting),
      .best_err_count (best_err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Error flag for cycle k after launch: always set during settle (must be
   // ignored), then rate[code] ones at the head of each measure window.
   function automatic logic err_at(input int k, input int deff);
      int per, idx, off;
      per = SETTLE + deff + 1;
      idx = k / per;
      off = k % per;
      if (idx > 15)               return 1'b0;
      if (off < SETTLE)           return 1'b1;
      if (off < SETTLE + deff)    return ((off - SETTLE) < rate[idx]);
      return 1'b0;
   endfunction

   task automatic run_sweep(input logic [3:0] mn, input logic [3:0] mx, input logic [15:0] dw,
                            input logic [3:0] exp_best, input logic [15:0] exp_cnt);
      int   deff, lat;
      bit   seen;
      exp_t e;
      deff = (dw == 16'd0) ? 1 : int'(dw);
      lat  = (int'(mx) - int'(mn) + 1) * (SETTLE + deff + 1) + 1;
      sb.push_back('{exp_best, exp_cnt, lat});
      setting_min  = mn;
      setting_max  = mx;
      dwell_cycles = dw;
      start        = 1'b1;
      err_in       = 1'b0;
      seen         = 1'b0;
      for (int k = 0; k <= lat + 5 && !seen; k++) begin
         tick();
         start = 1'b0;
         if (k == 0) begin
            chk("sweep_first_code", 32'(tx_setting), 32'(mn));
            chk("sweep_busy", 32'(busy), 32'd1);
         end
         if (k == 100 && lat > 200) begin
            start        = 1'b1;
            setting_min  = 4'd0;
            setting_max  = 4'd15;
            dwell_cycles = 16'd1;
         end
         if (done) begin
            e = sb.pop_front();
            chk("done_latency", 32'(k), 32'(e.lat));
            chk("best_setting", 32'(best_setting), 32'(e.best));
            chk("best_err_count", 32'(best_err_count), 32'(e.cnt));
            chk("tx_applied", 32'(tx_setting), 32'(e.best));
            chk("busy_at_done", 32'(busy), 32'd0);
            seen = 1'b1;
         end
         err_in = err_at(k, deff);
      end
      if (!seen) begin
         void'(sb.pop_front());
         chk("done_timeout", 32'd0, 32'd1);
      end
      err_in = 1'b0;
      tick();
      chk("done_pulse_width", 32'(done), 32'd0);
      $display("sweep min=%0d max=%0d dwell=%0d -> best=%0d cnt=%0d tx=%0d",
               mn, mx, dw, best_setting, best_err_count, tx_setting);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      err_in       = 1'b0;
      setting_min  = 4'd0;
      setting_max  = 4'd0;
      dwell_cycles = 16'd0;
      repeat (3) tick();
      chk("rst_tx", 32'(tx_setting), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_range_err", 32'(range_err), 32'd0);
      chk("rst_best_setting", 32'(best_setting), 32'd0);
      chk("rst_best_cnt", 32'(best_err_count), 32'hFFFF);
      rst = 1'b0;
      tick();
      $display("reset: tx=%0d busy=%0d best_cnt=%0h", tx_setting, busy, best_err_count);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_busy", 32'(busy), 32'd0);
      chk("idle_abort_tx", 32'(tx_setting), 32'd0);
      $display("idle abort: busy=%0d tx=%0d", busy, tx_setting);

      rate = '{default: 0};
      rate[0] = 9; rate[1] = 1; rate[2] = 1; rate[3] = 7;
      run_sweep(4'd2, 4'd5, 16'd100, 4'd3, 16'd1);

      rate = '{default: 0};
      rate[0] = 1;
      run_sweep(4'd15, 4'd15, 16'd0, 4'd15, 16'd1);

      rate = '{default: 0};
      rate[0] = 70000;
      run_sweep(4'd9, 4'd9, 16'hFFFF, 4'd9, 16'hFFFF);

      setting_min = 4'd6;
      setting_max = 4'd3;
      start       = 1'b1;
      tick();
      start = 1'b0;
      chk("range_err_pulse", 32'(range_err), 32'd1);
      chk("range_busy", 32'(busy), 32'd0);
      chk("range_tx", 32'(tx_setting), 32'd9);
      tick();
      chk("range_err_clear", 32'(range_err), 32'd0);
      chk("range_busy2", 32'(busy), 32'd0);
      chk("range_best", 32'(best_setting), 32'd9);
      $display("range error: tx=%0d busy=%0d", tx_setting, busy);

      rate = '{default: 0};
      run_sweep(4'd7, 4'd7, 16'd0, 4'd7, 16'd0);

      // Abort during the measure window of the third code (k 214..223).
      setting_min  = 4'd2;
      setting_max  = 4'd5;
      dwell_cycles = 16'd10;
      start        = 1'b1;
      for (int k = 0; k <= 216; k++) begin
         tick();
         start  = 1'b0;
         err_in = 1'b1;
         if (k == 216) abort = 1'b1;
      end
      tick();
      abort  = 1'b0;
      err_in = 1'b0;
      chk("abort_tx_restore", 32'(tx_setting), 32'd7);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(done), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_no_done_later", 32'(done), 32'd0);
      end
      chk("abort_best_setting", 32'(best_setting), 32'd7);
      chk("abort_best_cnt", 32'(best_err_count), 32'd0);
      $display("abort: tx=%0d busy=%0d best=%0d", tx_setting, busy, best_setting);

      setting_min  = 4'd4;
      setting_max  = 4'd5;
      dwell_cycles = 16'd3;
      start        = 1'b1;
      abort        = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_wins_busy", 32'(busy), 32'd1);
      chk("start_wins_tx", 32'(tx_setting), 32'd4);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      chk("midrst_tx", 32'(tx_setting), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_best_setting", 32'(best_setting), 32'd0);
      chk("midrst_best_cnt", 32'(best_err_count), 32'hFFFF);
      rst = 1'b0;
      tick();
      $display("mid-settle reset: tx=%0d busy=%0d", tx_setting, busy);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
